cc_cond_unit: RTL and testbench
===============================

Name: cc_cond_unit

Overview:
- Execute-stage condition-code register plus branch/move condition evaluator for the Y86-64 SEQ datapath.
- Sits directly downstream of the ALU flag generators (add/sub/and/xor 64-bit units).
  - Latches the selected 3-bit flag vector {OF,SF,ZF} when an OPq instruction retires its execute stage.
  - Produces `cnd`, consumed by jXX next-PC selection and cmovXX destination-write enable.

Parameters:
- CC_W, 3, width of condition-code vector; bit0=ZF, bit1=SF, bit2=OF (same packing as the ALU flag outputs).
- CC_RESET, 3'b001, CC value loaded on reset (ZF=1, SF=0, OF=0).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- icode  input  4  current instruction code from decode.
- ifun  input  4  current function code from decode.
- alu_cc  input  CC_W  flag vector from the ALU flag mux for the current instruction.
- stat_ok  input  1  1 = instruction status AOK; 0 = HLT/ADR/INS (CC must not change).
- stall  input  1  1 = hold the CC register this cycle.
- cc  output  CC_W  registered condition codes.
- cnd  output  1  condition-true for the current jXX/cmovXX, evaluated from `cc`.
- cond_err  output  1  ifun outside 0..6 while icode is 2 or 7.

Behaviour:
- One clock; reset is synchronous and active-low: on a rising `clk` edge with `rst_n`=0, `cc` <= CC_RESET. All other inputs are ignored that cycle.
- Reset applies mid-operation with no exceptions: a pending CC write in the same cycle is discarded.
- CC write enable is `set_cc` = (icode==4'h6) & stat_ok & ~stall & rst_n.
  - `set_cc`=1: `cc` <= `alu_cc` at the rising edge. Latency is 1 cycle; new flags are visible on `cc` the cycle after the OPq.
  - Otherwise `cc` holds.
- `cnd` and `cond_err` are combinational from `cc`, `icode` and `ifun` only. They have zero latency and are never affected by `alu_cc` in the same cycle, so a jXX always sees flags from the last retired OPq.
- Condition table, evaluated on registered `cc`, with lt = SF^OF:
  - ifun 0 -> 1
  - ifun 1 (le) -> lt|ZF
  - ifun 2 (l) -> lt
  - ifun 3 (e) -> ZF
  - ifun 4 (ne) -> ~ZF
  - ifun 5 (ge) -> ~lt
  - ifun 6 (g) -> ~lt & ~ZF
- When icode is 2 (rrmov/cmovXX) or 7 (jXX): `cnd` follows the condition table. If ifun > 6, `cnd`=0 and `cond_err`=1.
- For any other icode: `cnd`=0 and `cond_err`=0.
- While `rst_n`=0, outputs follow the table using `cc` as held. After the reset edge, `cc`=3'b001, so jXX ifun 3 (e) gives `cnd`=1.
- `stat_ok`=0 on an OPq blocks the update, so faulting instructions never corrupt CC. `stall`=1 blocks the update regardless of icode.
- `alu_cc` bits are taken verbatim; no width extension.

Decomposition:
- Shared package/include `y86_defs` holds:
  - icode constants: I_HALT, I_NOP, I_RRMOVQ=2, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ=6, I_JXX=7, I_CALL, I_RET, I_PUSHQ, I_POPQ.
  - ifun condition constants: C_YES..C_G.
  - CC bit index constants: CC_ZF=0, CC_SF=1, CC_OF=2.
- One sub-module: `cond_eval` (pure combinational condition table: cc, ifun -> cnd_raw, ifun_bad), instantiated once. Register and enable logic stay in the top.

Test Plan:
- Reset: hold `rst_n`=0 for 2 cycles with `icode`=6, `alu_cc`=3'b110 -> `cc`=3'b001 after the edge. Then icode=7, ifun=3 -> `cnd`=1; ifun=4 -> `cnd`=0.
- OPq update: icode=6, stat_ok=1, `alu_cc`=3'b010 (SF) -> next cycle `cc`=3'b010. Then icode=7 gives:
  - ifun=2 -> `cnd`=1
  - ifun=6 -> `cnd`=0
  - ifun=5 -> `cnd`=0
- Hold conditions: icode=6 with stall=1 and `alu_cc`=3'b000 -> `cc` unchanged. icode=6, stat_ok=0 -> unchanged. icode=3, `alu_cc`=3'b111 -> unchanged.
- Overflow: load `cc`=3'b110 (OF,SF). Then icode=2:
  - ifun=5 (ge) -> `cnd`=1
  - ifun=2 (l) -> `cnd`=0
  - ifun=1 (le) -> `cnd`=0
- Same-cycle ordering: with `cc`=3'b001, drive icode=6, `alu_cc`=3'b000, and observe that cycle icode/ifun decode for jXX ifun=3 -> `cnd`=1 before the edge; re-evaluated after the edge -> `cnd`=0.
- Illegal ifun: icode=7, ifun=4'hA -> `cnd`=0, `cond_err`=1. icode=1, ifun=4'hA -> `cnd`=0, `cond_err`=0.

Source files
------------

// File: rtl/y86_defs.sv
// y86_defs: shared Y86-64 instruction, condition and flag-index constants
package y86_defs;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;
  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: Y86-64 jXX/cmovXX condition table over {OF,SF,ZF}
module cond_eval
  import y86_defs::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd_raw,
  output logic       ifun_bad
);
  logic lt, zf;
  // evaluate the selected condition; unknown function codes are flagged
  always_comb begin
    lt       = cc[CC_SF] ^ cc[CC_OF];
    zf       = cc[CC_ZF];
    ifun_bad = ifun > C_G;
    cnd_raw  = ifun == C_YES ? 1'b1 :
               ifun == C_LE  ? lt | zf :
               ifun == C_L   ? lt :
               ifun == C_E   ? zf :
               ifun == C_NE  ? ~zf :
               ifun == C_GE  ? ~lt :
               ifun == C_G   ? ~lt & ~zf : 1'b0;
  end
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: condition-code register and jXX/cmovXX condition evaluator
module cc_cond_unit
  import y86_defs::*;
#(
  parameter int            CC_W     = 3,
  parameter logic [CC_W-1:0] CC_RESET = 3'b001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [CC_W-1:0] alu_cc,
  input  logic            stat_ok,
  input  logic            stall,
  output logic [CC_W-1:0] cc,
  output logic            cnd,
  output logic            cond_err
);
  logic [CC_W-1:0] cc_d, cc_q;
  logic set_cc, is_cond, cnd_raw, ifun_bad;
  cond_eval u_cond_eval (
    .cc       (cc_q),
    .ifun     (ifun),
    .cnd_raw  (cnd_raw),
    .ifun_bad (ifun_bad)
  );
  // only a healthy, unstalled OPq updates the flags; outputs use registered cc
  always_comb begin
    set_cc   = (icode == I_OPQ) & stat_ok & ~stall & rst_n;
    cc_d     = set_cc ? alu_cc : cc_q;
    is_cond  = (icode == I_RRMOVQ) | (icode == I_JXX);
    cnd      = is_cond & cnd_raw & ~ifun_bad;
    cond_err = is_cond & ifun_bad;
    cc       = cc_q;
  end
  // flag register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) cc_q <= CC_RESET;
    else        cc_q <= cc_d;
  end
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: directed vectors with a queue scoreboard and decoupled monitor
module tb_cc_cond_unit;
  typedef struct {
    int       id;
    logic [2:0] cc;
    logic     cnd;
    logic     err;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] icode = 4'h0, ifun = 4'h0;
  logic [2:0] alu_cc = 3'b000;
  logic       stat_ok = 1'b1, stall = 1'b0;
  logic [2:0] cc;
  logic       cnd, cond_err;
  exp_t       sb[$];
  int         n_run = 0, n_fail = 0, vec = 0;
  cc_cond_unit dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .alu_cc(alu_cc),
    .stat_ok(stat_ok), .stall(stall), .cc(cc), .cnd(cnd), .cond_err(cond_err)
  );
  always #5 clk = ~clk;
  // monitor: outputs are valid every cycle; compare mid-cycle against the queue
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_run++;
      if ({cc, cnd, cond_err} !== {e.cc, e.cnd, e.err}) begin
        n_fail++;
        $display("FAIL v%0d got cc=%b cnd=%b err=%b want cc=%b cnd=%b err=%b",
                 e.id, cc, cnd, cond_err, e.cc, e.cnd, e.err);
      end
    end
  end
  task automatic step(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [2:0] alu, input logic ok, input logic st,
                      input logic chk, input logic [2:0] ecc, input logic ecnd,
                      input logic eerr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; icode = ic; ifun = fn; alu_cc = alu; stat_ok = ok; stall = st;
    vec++;
    if (chk) begin
      e.id = vec; e.cc = ecc; e.cnd = ecnd; e.err = eerr;
      sb.push_back(e);
    end
  endtask
  initial begin
    //     rst  ic    fn    alu     ok stl chk cc      cnd  err
    step(0, 4'h6, 4'h0, 3'b110, 1, 0, 0, 3'b000, 0, 0);
    step(0, 4'h6, 4'h0, 3'b110, 1, 0, 1, 3'b001, 0, 0);
    step(1, 4'h7, 4'h3, 3'b110, 1, 0, 1, 3'b001, 1, 0);
    step(1, 4'h7, 4'h4, 3'b110, 1, 0, 1, 3'b001, 0, 0);
    step(1, 4'h6, 4'h0, 3'b010, 1, 0, 1, 3'b001, 0, 0);
    step(1, 4'h7, 4'h2, 3'b000, 1, 0, 1, 3'b010, 1, 0);
    step(1, 4'h7, 4'h6, 3'b000, 1, 0, 1, 3'b010, 0, 0);
    step(1, 4'h7, 4'h5, 3'b000, 1, 0, 1, 3'b010, 0, 0);
    step(1, 4'h6, 4'h0, 3'b000, 1, 1, 1, 3'b010, 0, 0);
    step(1, 4'h6, 4'h0, 3'b000, 0, 0, 1, 3'b010, 0, 0);
    step(1, 4'h3, 4'h0, 3'b111, 1, 0, 1, 3'b010, 0, 0);
    step(1, 4'h6, 4'h0, 3'b110, 1, 0, 1, 3'b010, 0, 0);
    step(1, 4'h2, 4'h5, 3'b000, 1, 0, 1, 3'b110, 1, 0);
    step(1, 4'h2, 4'h2, 3'b000, 1, 0, 1, 3'b110, 0, 0);
    step(1, 4'h2, 4'h1, 3'b000, 1, 0, 1, 3'b110, 0, 0);
    step(1, 4'h2, 4'h6, 3'b000, 1, 0, 1, 3'b110, 1, 0);
    step(1, 4'h6, 4'h0, 3'b001, 1, 0, 1, 3'b110, 0, 0);
    step(1, 4'h7, 4'h3, 3'b000, 1, 0, 1, 3'b001, 1, 0);
    step(1, 4'h6, 4'h0, 3'b000, 1, 0, 1, 3'b001, 0, 0);
    step(1, 4'h7, 4'h3, 3'b111, 1, 0, 1, 3'b000, 0, 0);
    step(1, 4'h7, 4'hA, 3'b000, 1, 0, 1, 3'b000, 0, 1);
    step(1, 4'h1, 4'hA, 3'b000, 1, 0, 1, 3'b000, 0, 0);
    step(1, 4'h2, 4'hF, 3'b000, 1, 0, 1, 3'b000, 0, 1);
    step(1, 4'h7, 4'h0, 3'b000, 1, 0, 1, 3'b000, 1, 0);
    step(0, 4'h6, 4'h0, 3'b100, 1, 0, 1, 3'b000, 0, 0);
    step(1, 4'h7, 4'h3, 3'b000, 1, 0, 1, 3'b001, 1, 0);
    step(1, 4'h2, 4'h4, 3'b000, 1, 0, 1, 3'b001, 0, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
